umi_pack_buf: RTL and testbench

UMI_PACK_BUF -- requirements
Module: umi_pack_buf

---
 rtl/umi_pack_buf_pkg.sv | 53 +++++
 rtl/umi_skid_buf.sv | 73 +++++++
 rtl/umi_pack_buf.sv | 131 +++++++++++++
 tb/tb_umi_pack_buf.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pack_buf_pkg.sv
// Shared UMI message constants, command-word bit positions and the opcode classifier
// used by the command packer and its output buffer.
package umi_pack_buf_pkg;

  localparam logic [4:0] UMI_INVALID    = 5'h00;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;
  localparam logic [4:0] UMI_RESP_LINK  = 5'h0E;
  localparam logic [4:0] UMI_REQ_LINK   = 5'h0F;

  localparam logic [2:0] UMI_SIZE_LINK  = 3'h1;
  localparam logic [2:0] UMI_SIZE_ERROR = 3'h0;

  localparam int OPC_LSB    = 0;
  localparam int SIZE_LSB   = 5;
  localparam int LEN_LSB    = 8;
  localparam int QOS_LSB    = 16;
  localparam int PROT_LSB   = 20;
  localparam int EOM_BIT    = 22;
  localparam int EOF_BIT    = 23;
  localparam int EX_BIT     = 24;
  localparam int UERR_LSB   = 25;
  localparam int ERRU_LSB   = 22;
  localparam int HOSTID_LSB = 27;

  typedef enum logic [2:0] {
    CLS_LINK,
    CLS_ERROR,
    CLS_LINK_RESP,
    CLS_INVALID,
    CLS_REQUEST,
    CLS_RESPONSE
  } umi_class_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  // Priority order matters: link/error share opcode 0F and must be caught before the
  // generic odd-opcode request rule.
  function automatic umi_class_e classify(input logic [4:0] opcode, input logic [2:0] size);
    umi_class_e cls;
    if (opcode == UMI_REQ_LINK && size == UMI_SIZE_LINK)       cls = CLS_LINK;
    else if (opcode == UMI_REQ_LINK && size == UMI_SIZE_ERROR) cls = CLS_ERROR;
    else if (opcode == UMI_RESP_LINK)                          cls = CLS_LINK_RESP;
    else if (opcode == UMI_INVALID)                            cls = CLS_INVALID;
    else if (opcode[0])                                        cls = CLS_REQUEST;
    else                                                       cls = CLS_RESPONSE;
    return cls;
  endfunction

endpackage

// File: rtl/umi_skid_buf.sv
// Two-entry skid buffer: an output register backed by one skid register, so the
// upstream ready can be a flop while still sustaining one transfer per cycle.
module umi_skid_buf
  import umi_pack_buf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         ready
);

  skid_state_e  state_reg;
  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         valid_reg;
  logic         ready_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (push) begin
            out_reg   <= push_data;
            valid_reg <= 1'b1;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && push) begin
            out_reg <= push_data;
          end else if (pop) begin
            valid_reg <= 1'b0;
            state_reg <= ST_EMPTY;
          end else if (push) begin
            skid_reg  <= push_data;
            ready_reg <= 1'b0;
            state_reg <= ST_TWO;
          end
        end
        ST_TWO: begin
          // ready is low here, so nothing new can arrive while draining the skid
          if (pop) begin
            out_reg   <= skid_reg;
            ready_reg <= 1'b1;
            state_reg <= ST_ONE;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = out_reg;
  assign ready     = ready_reg;

endmodule

// File: rtl/umi_pack_buf.sv
// Packs unpacked UMI command fields into a 32-bit command word according to the
// message class and forwards the packet through a two-entry skid buffer.
module umi_pack_buf
  import umi_pack_buf_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    cmd_opcode,
  input  logic [2:0]    cmd_size,
  input  logic [7:0]    cmd_len,
  input  logic [7:0]    cmd_atype,
  input  logic [3:0]    cmd_qos,
  input  logic [1:0]    cmd_prot,
  input  logic          cmd_eom,
  input  logic          cmd_eof,
  input  logic          cmd_ex,
  input  logic [22:0]   cmd_user,
  input  logic [1:0]    cmd_err,
  input  logic [4:0]    cmd_hostid,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [DW-1:0] in_data,
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          clr_invalid,
  output logic          invalid_seen
);

  localparam int W = CW + 2 * AW + DW;

  function automatic logic [31:0] pack_cmd(
    input umi_class_e  cls,
    input logic [4:0]  opcode,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [7:0]  atype,
    input logic [3:0]  qos,
    input logic [1:0]  prot,
    input logic        eom,
    input logic        eof,
    input logic        ex,
    input logic [22:0] user,
    input logic [1:0]  err,
    input logic [4:0]  hostid
  );
    logic [31:0] cmd;
    cmd = '0;
    cmd[OPC_LSB +: 5]    = opcode;
    cmd[SIZE_LSB +: 3]   = size;
    cmd[HOSTID_LSB +: 5] = hostid;
    case (cls)
      CLS_LINK: begin
        cmd[LEN_LSB +: 19] = user[18:0];
      end
      CLS_LINK_RESP: begin
        cmd[LEN_LSB +: 17]  = user[16:0];
        cmd[UERR_LSB +: 2]  = err;
      end
      CLS_ERROR: begin
        cmd[LEN_LSB +: 8]   = user[7:0];
        cmd[QOS_LSB +: 4]   = qos;
        cmd[PROT_LSB +: 2]  = prot;
        cmd[ERRU_LSB +: 3]  = user[10:8];
        cmd[UERR_LSB +: 2]  = err;
      end
      default: begin
        // Request/response share a layout; only atomics swap len for atype and
        // only requests carry user bits in place of err.
        cmd[LEN_LSB +: 8]  = (opcode == UMI_REQ_ATOMIC) ? atype : len;
        cmd[QOS_LSB +: 4]  = qos;
        cmd[PROT_LSB +: 2] = prot;
        cmd[EOM_BIT]       = eom;
        cmd[EOF_BIT]       = eof;
        cmd[EX_BIT]        = ex;
        cmd[UERR_LSB +: 2] = (cls == CLS_REQUEST) ? user[1:0] : err;
      end
    endcase
    return cmd;
  endfunction

  umi_class_e   in_class;
  logic [31:0]  packed_cmd;
  logic         in_fire;
  logic         load;
  logic [W-1:0] out_word;
  logic         invalid_seen_reg;

  assign in_class   = classify(cmd_opcode, cmd_size);
  assign packed_cmd = pack_cmd(in_class, cmd_opcode, cmd_size, cmd_len, cmd_atype, cmd_qos,
                               cmd_prot, cmd_eom, cmd_eof, cmd_ex, cmd_user, cmd_err,
                               cmd_hostid);
  assign in_fire    = in_valid & in_ready;
  assign load       = in_fire & (in_class != CLS_INVALID);

  umi_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .nreset    (nreset),
    .push      (load),
    .push_data ({packed_cmd, in_dstaddr, in_srcaddr, in_data}),
    .pop       (umi_out_ready),
    .out_valid (umi_out_valid),
    .out_data  (out_word),
    .ready     (in_ready)
  );

  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = out_word;

  // Invalid packets are swallowed; setting has priority over a coincident clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      invalid_seen_reg <= 1'b0;
    end else if (in_fire && in_class == CLS_INVALID) begin
      invalid_seen_reg <= 1'b1;
    end else if (clr_invalid) begin
      invalid_seen_reg <= 1'b0;
    end
  end

  assign invalid_seen = invalid_seen_reg;

endmodule

// File: tb/tb_umi_pack_buf.sv
// Directed bench for umi_pack_buf: table of packing vectors plus hand-written
// backpressure, streaming, invalid-opcode and reset-while-full sequences.
module tb_umi_pack_buf;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    cmd_opcode;
  logic [2:0]    cmd_size;
  logic [7:0]    cmd_len;
  logic [7:0]    cmd_atype;
  logic [3:0]    cmd_qos;
  logic [1:0]    cmd_prot;
  logic          cmd_eom;
  logic          cmd_eof;
  logic          cmd_ex;
  logic [22:0]   cmd_user;
  logic [1:0]    cmd_err;
  logic [4:0]    cmd_hostid;
  logic [AW-1:0] in_dstaddr;
  logic [AW-1:0] in_srcaddr;
  logic [DW-1:0] in_data;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          clr_invalid;
  logic          invalid_seen;

  always #5 clk = ~clk;

  umi_pack_buf #(.CW(CW), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .cmd_opcode      (cmd_opcode),
    .cmd_size        (cmd_size),
    .cmd_len         (cmd_len),
    .cmd_atype       (cmd_atype),
    .cmd_qos         (cmd_qos),
    .cmd_prot        (cmd_prot),
    .cmd_eom         (cmd_eom),
    .cmd_eof         (cmd_eof),
    .cmd_ex          (cmd_ex),
    .cmd_user        (cmd_user),
    .cmd_err         (cmd_err),
    .cmd_hostid      (cmd_hostid),
    .in_dstaddr      (in_dstaddr),
    .in_srcaddr      (in_srcaddr),
    .in_data         (in_data),
    .umi_out_valid   (umi_out_valid),
    .umi_out_ready   (umi_out_ready),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .clr_invalid     (clr_invalid),
    .invalid_seen    (invalid_seen)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [7:0]  atype;
    logic [3:0]  qos;
    logic [1:0]  prot;
    logic        eom;
    logic        eof;
    logic        ex;
    logic [22:0] user;
    logic [1:0]  err;
    logic [4:0]  hostid;
    logic [31:0] exp_cmd;
  } vec_t;

  vec_t vecs[8];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    cmd_opcode = v.opc;
    cmd_size   = v.size;
    cmd_len    = v.len;
    cmd_atype  = v.atype;
    cmd_qos    = v.qos;
    cmd_prot   = v.prot;
    cmd_eom    = v.eom;
    cmd_eof    = v.eof;
    cmd_ex     = v.ex;
    cmd_user   = v.user;
    cmd_err    = v.err;
    cmd_hostid = v.hostid;
  endtask

  // Plain packet: only opcode and len set, so the expected word is {16'h0, len, 3'b0, opc}.
  task automatic drive_simple(input logic [4:0] opc, input logic [7:0] len);
    vec_t v;
    v = '{opc, 3'h0, len, 8'h00, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 23'h0, 2'h0, 5'h00, 32'h0};
    drive_vec(v);
  endtask

  initial begin
    vecs[0] = '{5'h03, 3'h2, 8'h07, 8'h00, 4'h1, 2'h2, 1'b1, 1'b0, 1'b0, 23'h000003, 2'h0, 5'h05, 32'h2E610743};
    vecs[1] = '{5'h0F, 3'h1, 8'h00, 8'h00, 4'hF, 2'h3, 1'b1, 1'b1, 1'b1, 23'h07FFFF, 2'h0, 5'h00, 32'h07FFFF2F};
    vecs[2] = '{5'h09, 3'h3, 8'h12, 8'hAB, 4'h0, 2'h0, 1'b0, 1'b0, 1'b1, 23'h000001, 2'h0, 5'h01, 32'h0B00AB69};
    vecs[3] = '{5'h02, 3'h0, 8'hFF, 8'h00, 4'hF, 2'h1, 1'b0, 1'b1, 1'b0, 23'h7FFFFF, 2'h2, 5'h1F, 32'hFC9FFF02};
    vecs[4] = '{5'h0F, 3'h0, 8'h55, 8'h00, 4'h3, 2'h2, 1'b0, 1'b0, 1'b0, 23'h0007A5, 2'h1, 5'h02, 32'h13E3A50F};
    vecs[5] = '{5'h0E, 3'h4, 8'h00, 8'h00, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 23'h712345, 2'h3, 5'h03, 32'h1F23458E};
    vecs[6] = '{5'h01, 3'h1, 8'h00, 8'h00, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 23'h7FFFFC, 2'h3, 5'h00, 32'h00000021};
    vecs[7] = '{5'h0F, 3'h1, 8'h00, 8'h00, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 23'h7C0000, 2'h3, 5'h00, 32'h0400002F};

    nreset        = 1'b0;
    in_valid      = 1'b0;
    umi_out_ready = 1'b0;
    clr_invalid   = 1'b0;
    in_dstaddr    = '0;
    in_srcaddr    = '0;
    in_data       = '0;
    drive_simple(5'h00, 8'h00);

    #12;
    chk("rst_valid", DW'(umi_out_valid), DW'(1'b0));
    chk("rst_ready", DW'(in_ready), DW'(1'b1));
    chk("rst_invalid_seen", DW'(invalid_seen), DW'(1'b0));
    chk("rst_cmd", DW'(umi_out_cmd), DW'(0));
    @(negedge clk);
    nreset = 1'b1;

    // Packing table: one packet at a time, sink always ready.
    umi_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      in_dstaddr = 64'h1000_0000_0000_0000 + 64'(i);
      in_srcaddr = 64'h2000_0000_0000_0000 + 64'(i);
      in_data    = {8{32'hA5A5_0000 + 32'(i)}};
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      $display("vec %0d: opc=%0h cmd=%h expected=%h", i, vecs[i].opc, umi_out_cmd, vecs[i].exp_cmd);
      chk($sformatf("vec%0d_valid", i), DW'(umi_out_valid), DW'(1'b1));
      chk($sformatf("vec%0d_cmd", i), DW'(umi_out_cmd), DW'(vecs[i].exp_cmd));
      chk($sformatf("vec%0d_dst", i), DW'(umi_out_dstaddr), DW'(64'h1000_0000_0000_0000 + 64'(i)));
      chk($sformatf("vec%0d_src", i), DW'(umi_out_srcaddr), DW'(64'h2000_0000_0000_0000 + 64'(i)));
      chk($sformatf("vec%0d_data", i), umi_out_data, {8{32'hA5A5_0000 + 32'(i)}});
    end
    @(negedge clk);
    chk("table_drained", DW'(umi_out_valid), DW'(1'b0));

    // Backpressure: A, B fill the buffer, C waits; order must be A, B, C.
    umi_out_ready = 1'b0;
    drive_simple(5'h03, 8'h0A);
    in_valid = 1'b1;
    @(negedge clk);
    $display("bp: A accepted cmd=%h in_ready=%b", umi_out_cmd, in_ready);
    chk("bp_a_valid", DW'(umi_out_valid), DW'(1'b1));
    chk("bp_a_cmd", DW'(umi_out_cmd), DW'(32'h00000A03));
    chk("bp_ready_after_a", DW'(in_ready), DW'(1'b1));
    drive_simple(5'h03, 8'h0B);
    @(negedge clk);
    $display("bp: B accepted cmd=%h in_ready=%b", umi_out_cmd, in_ready);
    chk("bp_ready_after_b", DW'(in_ready), DW'(1'b0));
    chk("bp_hold_a_1", DW'(umi_out_cmd), DW'(32'h00000A03));
    drive_simple(5'h03, 8'h0C);
    @(negedge clk);
    $display("bp: C offered cmd=%h in_ready=%b", umi_out_cmd, in_ready);
    chk("bp_c_blocked", DW'(in_ready), DW'(1'b0));
    chk("bp_hold_a_2", DW'(umi_out_cmd), DW'(32'h00000A03));
    umi_out_ready = 1'b1;
    @(negedge clk);
    $display("bp: after A pop cmd=%h in_ready=%b", umi_out_cmd, in_ready);
    chk("bp_b_out", DW'(umi_out_cmd), DW'(32'h00000B03));
    chk("bp_ready_back", DW'(in_ready), DW'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp: after B pop cmd=%h", umi_out_cmd);
    chk("bp_c_valid", DW'(umi_out_valid), DW'(1'b1));
    chk("bp_c_out", DW'(umi_out_cmd), DW'(32'h00000C03));
    @(negedge clk);
    chk("bp_drained", DW'(umi_out_valid), DW'(1'b0));

    // Stream: eight back-to-back packets, one out_fire per cycle.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_simple(5'h02, 8'h20 + 8'(k));
      @(negedge clk);
      $display("stream %0d: cmd=%h valid=%b in_ready=%b", k, umi_out_cmd, umi_out_valid, in_ready);
      chk($sformatf("stream%0d_valid", k), DW'(umi_out_valid), DW'(1'b1));
      chk($sformatf("stream%0d_cmd", k), DW'(umi_out_cmd), DW'({16'h0, 8'h20 + 8'(k), 8'h02}));
      chk($sformatf("stream%0d_ready", k), DW'(in_ready), DW'(1'b1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", DW'(umi_out_valid), DW'(1'b0));

    // Invalid opcode: consumed, flagged, sticky until cleared; set beats clear.
    drive_simple(5'h00, 8'h33);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("invalid: valid=%b invalid_seen=%b", umi_out_valid, invalid_seen);
    chk("inv_no_valid", DW'(umi_out_valid), DW'(1'b0));
    chk("inv_seen", DW'(invalid_seen), DW'(1'b1));
    repeat (3) @(negedge clk);
    chk("inv_sticky", DW'(invalid_seen), DW'(1'b1));
    in_valid    = 1'b1;
    clr_invalid = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    clr_invalid = 1'b0;
    $display("invalid: set+clear invalid_seen=%b", invalid_seen);
    chk("inv_set_wins", DW'(invalid_seen), DW'(1'b1));
    clr_invalid = 1'b1;
    @(negedge clk);
    clr_invalid = 1'b0;
    $display("invalid: clear invalid_seen=%b", invalid_seen);
    chk("inv_cleared", DW'(invalid_seen), DW'(1'b0));

    // Reset while full: outputs drop without a clock edge, then behave as from empty.
    umi_out_ready = 1'b0;
    drive_simple(5'h01, 8'h41);
    in_valid = 1'b1;
    @(negedge clk);
    drive_simple(5'h01, 8'h42);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2_full", DW'(in_ready), DW'(1'b0));
    #2 nreset = 1'b0;
    #1;
    $display("reset in TWO: valid=%b in_ready=%b cmd=%h", umi_out_valid, in_ready, umi_out_cmd);
    chk("rst2_valid", DW'(umi_out_valid), DW'(1'b0));
    chk("rst2_ready", DW'(in_ready), DW'(1'b1));
    chk("rst2_cmd", DW'(umi_out_cmd), DW'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    umi_out_ready = 1'b1;
    drive_simple(5'h01, 8'h43);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("after reset: valid=%b cmd=%h", umi_out_valid, umi_out_cmd);
    chk("rst2_next_valid", DW'(umi_out_valid), DW'(1'b1));
    chk("rst2_next_cmd", DW'(umi_out_cmd), DW'(32'h00004301));
    @(negedge clk);
    chk("rst2_drained", DW'(umi_out_valid), DW'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
